// File: rtl/bpf_decode_buf_if.sv
// Decode-stage bus: fetch-side push handshake, flush, and the decoded head
// entry presented to execute. The slave modport is the decode buffer's view.
interface bpf_decode_buf_if #(
  parameter int CODE_W    = 8,
  parameter int JMP_W     = 8,
  parameter int IMM_W     = 32,
  parameter int BUF_DEPTH = 2,
  parameter int COUNT_W   = 6
);
  localparam int INST_W = CODE_W + 2*JMP_W + IMM_W;
  localparam int OCC_W  = $clog2(BUF_DEPTH) + 1;

  logic [INST_W-1:0]  inst;
  logic               prev_vld;
  logic               rdy;
  logic [COUNT_W-1:0] icount;
  logic               branch_mispredict;
  logic               next_rdy;
  logic               vld;
  logic [CODE_W-1:0]  opcode;
  logic [JMP_W-1:0]   jt;
  logic [JMP_W-1:0]   jf;
  logic [IMM_W-1:0]   imm;
  logic               B_sel;
  logic [3:0]         ALU_sel;
  logic               addr_sel;
  logic               rd_en;
  logic               regfile_sel;
  logic               regfile_wr_en;
  logic               illegal;
  logic [COUNT_W-1:0] ocount;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output inst, prev_vld, icount, branch_mispredict, next_rdy,
    input  rdy, vld, opcode, jt, jf, imm, B_sel, ALU_sel, addr_sel, rd_en,
           regfile_sel, regfile_wr_en, illegal, ocount, occupancy
  );

  modport slave (
    input  inst, prev_vld, icount, branch_mispredict, next_rdy,
    output rdy, vld, opcode, jt, jf, imm, B_sel, ALU_sel, addr_sel, rd_en,
           regfile_sel, regfile_wr_en, illegal, ocount, occupancy
  );
endinterface

// File: rtl/bpf_decode_buf.sv
// BPF decode stage: decodes incoming instruction words and buffers the
// decoded bundles in a small FIFO with per-entry saturating age counters.
// A mispredict flush empties the buffer in one cycle.
module bpf_decode_buf #(
  parameter int CODE_W    = 8,
  parameter int JMP_W     = 8,
  parameter int IMM_W     = 32,
  parameter int INST_W    = CODE_W + 2*JMP_W + IMM_W,
  parameter int BUF_DEPTH = 2,
  parameter int COUNT_W   = 6
) (
  input logic             clk,
  input logic             rst,
  bpf_decode_buf_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [COUNT_W-1:0] AGE_MAX = '1;

  localparam logic [2:0] CL_LD  = 3'd0;
  localparam logic [2:0] CL_LDX = 3'd1;
  localparam logic [2:0] CL_ST  = 3'd2;
  localparam logic [2:0] CL_STX = 3'd3;
  localparam logic [2:0] CL_RET = 3'd6;
  localparam logic [2:0] AT_ABS = 3'd1;
  localparam logic [2:0] AT_IND = 3'd2;
  localparam logic [2:0] AT_MSH = 3'd5;

  typedef struct packed {
    logic [CODE_W-1:0] opcode;
    logic [JMP_W-1:0]  jt;
    logic [JMP_W-1:0]  jf;
    logic [IMM_W-1:0]  imm;
    logic              addr_sel;
    logic              rd_en;
    logic              regfile_sel;
    logic              regfile_wr_en;
    logic              illegal;
  } entry_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  entry_t                            mem_q [BUF_DEPTH];
  entry_t                            mem_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0][COUNT_W-1:0] age_q, age_d;
  logic [PTR_W-1:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0]                  occ_q, occ_d;

  logic [CODE_W-1:0] in_op;
  logic [2:0]        cls, at;
  entry_t            dec, head;
  logic              vld_w, pop, rdy_w, push;

  assign in_op = bus.inst[INST_W-1 -: CODE_W];
  assign cls   = in_op[2:0];
  assign at    = in_op[7:5];

  // Combinational decode of the offered instruction into a buffer entry
  always_comb begin
    dec               = '0;
    dec.opcode        = in_op;
    dec.jt            = bus.inst[IMM_W+2*JMP_W-1 -: JMP_W];
    dec.jf            = bus.inst[IMM_W+JMP_W-1 -: JMP_W];
    dec.imm           = bus.inst[IMM_W-1:0];
    dec.addr_sel      = (at == AT_IND);
    dec.rd_en         = ((cls == CL_LD)  && (at == AT_ABS || at == AT_IND)) ||
                        ((cls == CL_LDX) && (at == AT_ABS || at == AT_IND || at == AT_MSH));
    dec.regfile_sel   = (cls == CL_STX);
    dec.regfile_wr_en = (cls == CL_ST) || (cls == CL_STX);
    dec.illegal       = ((cls == CL_LD)  && (at >= AT_MSH)) ||
                        ((cls == CL_LDX) && (at >= 3'd6)) ||
                        ((cls == CL_RET) && (in_op[4:3] == 2'b11));
  end

  // A full buffer that is popping this cycle can still accept; flush blocks pushes
  assign vld_w = (occ_q != '0);
  assign pop   = vld_w & bus.next_rdy;
  assign rdy_w = ~bus.branch_mispredict & ((occ_q < OCC_W'(BUF_DEPTH)) | pop);
  assign push  = bus.prev_vld & rdy_w;

  // Next-state for storage, ages, pointers and occupancy; flush overrides all
  always_comb begin
    mem_d  = mem_q;
    age_d  = age_q;
    wptr_d = wptr_q + PTR_W'(push);
    rptr_d = rptr_q + PTR_W'(pop);
    occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
    // Aging every slot is harmless: a free slot is rewritten on push
    for (int i = 0; i < BUF_DEPTH; i++) age_d[i] = sat_inc(age_q[i]);
    if (push) begin
      mem_d[wptr_q] = dec;
      age_d[wptr_q] = sat_inc(bus.icount);
    end
    if (bus.branch_mispredict) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      age_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      age_q  <= age_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Head outputs come straight from storage and read as zero when empty
  assign head              = vld_w ? mem_q[rptr_q] : '0;
  assign bus.rdy           = rdy_w;
  assign bus.vld           = vld_w;
  assign bus.opcode        = head.opcode;
  assign bus.jt            = head.jt;
  assign bus.jf            = head.jf;
  assign bus.imm           = head.imm;
  assign bus.B_sel         = head.opcode[3];
  assign bus.ALU_sel       = head.opcode[7:4];
  assign bus.addr_sel      = head.addr_sel;
  assign bus.rd_en         = head.rd_en;
  assign bus.regfile_sel   = head.regfile_sel;
  assign bus.regfile_wr_en = head.regfile_wr_en;
  assign bus.illegal       = head.illegal;
  assign bus.ocount        = vld_w ? age_q[rptr_q] : '0;
  assign bus.occupancy     = occ_q;
endmodule

// File: tb/tb_bpf_decode_buf.sv
// Scoreboard bench for bpf_decode_buf: the driver offers directed vectors,
// the monitor queues accepted ones and checks every head cycle against them.
module tb_bpf_decode_buf;
  localparam int CODE_W = 8, JMP_W = 8, IMM_W = 32, BUF_DEPTH = 2, COUNT_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bpf_decode_buf_if #(.CODE_W(CODE_W), .JMP_W(JMP_W), .IMM_W(IMM_W),
                      .BUF_DEPTH(BUF_DEPTH), .COUNT_W(COUNT_W)) bus ();

  bpf_decode_buf #(.CODE_W(CODE_W), .JMP_W(JMP_W), .IMM_W(IMM_W),
                   .BUF_DEPTH(BUF_DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  jt;
    logic [7:0]  jf;
    logic [31:0] imm;
    logic        rd, rs, we, il, as;
    int          icnt;
    int          cyc;
  } exp_t;

  // Hand-decoded opcode table: rd_en, regfile_sel, regfile_wr_en, illegal, addr_sel
  logic [7:0] t_op [10] = '{8'h20, 8'h03, 8'hA0, 8'hB1, 8'h40, 8'h02, 8'hC1, 8'h1E, 8'h61, 8'h45};
  logic       t_rd [10] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
  logic       t_rs [10] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
  logic       t_we [10] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
  logic       t_il [10] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
  logic       t_as [10] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};

  exp_t q[$];
  exp_t cur;
  int   nerr = 0, nchk = 0, cyc = 0, acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int k, input int icnt, input logic [31:0] imm);
    cur.op   = t_op[k%10];
    cur.jt   = 8'(k);
    cur.jf   = ~8'(k);
    cur.imm  = imm;
    cur.rd   = t_rd[k%10];
    cur.rs   = t_rs[k%10];
    cur.we   = t_we[k%10];
    cur.il   = t_il[k%10];
    cur.as   = t_as[k%10];
    cur.icnt = icnt;
    cur.cyc  = 0;
    bus.inst   = {cur.op, cur.jt, cur.jf, cur.imm};
    bus.icount = 6'(icnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks handshake and head contents, then updates the scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   age;
    logic exp_rdy;
    if (!rst) begin
      q.delete();
    end else begin
      exp_rdy = !bus.branch_mispredict &&
                (q.size() < BUF_DEPTH || (q.size() != 0 && bus.next_rdy));
      chk("vld", 64'(bus.vld), 64'(q.size() != 0));
      chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
      chk("rdy", 64'(bus.rdy), 64'(exp_rdy));
      if (q.size() != 0) begin
        e   = q[0];
        age = e.icnt + (cyc - e.cyc);
        if (age > 63) age = 63;
      end else begin
        e   = '{op: 0, jt: 0, jf: 0, imm: 0, rd: 0, rs: 0, we: 0, il: 0, as: 0, icnt: 0, cyc: 0};
        age = 0;
      end
      chk("opcode", 64'(bus.opcode), 64'(e.op));
      chk("jt", 64'(bus.jt), 64'(e.jt));
      chk("jf", 64'(bus.jf), 64'(e.jf));
      chk("imm", 64'(bus.imm), 64'(e.imm));
      chk("B_sel", 64'(bus.B_sel), 64'(e.op[3]));
      chk("ALU_sel", 64'(bus.ALU_sel), 64'(e.op[7:4]));
      chk("addr_sel", 64'(bus.addr_sel), 64'(e.as));
      chk("rd_en", 64'(bus.rd_en), 64'(e.rd));
      chk("regfile_sel", 64'(bus.regfile_sel), 64'(e.rs));
      chk("regfile_wr_en", 64'(bus.regfile_wr_en), 64'(e.we));
      chk("illegal", 64'(bus.illegal), 64'(e.il));
      chk("ocount", 64'(bus.ocount), 64'(age));
      if (bus.branch_mispredict) begin
        q.delete();
      end else begin
        if (q.size() != 0 && bus.next_rdy) void'(q.pop_front());
        if (bus.prev_vld && exp_rdy) begin
          e     = cur;
          e.cyc = cyc;
          q.push_back(e);
          acc_cnt++;
        end
      end
    end
  end

  initial begin
    int start;
    bus.inst = '0; bus.prev_vld = 1'b0; bus.icount = '0;
    bus.branch_mispredict = 1'b0; bus.next_rdy = 1'b0;
    cur = '{op: 0, jt: 0, jf: 0, imm: 0, rd: 0, rs: 0, we: 0, il: 0, as: 0, icnt: 0, cyc: 0};

    // Reset state
    #2;
    chk("reset_vld", 64'(bus.vld), 64'd0);
    chk("reset_occ", 64'(bus.occupancy), 64'd0);
    chk("reset_ocount", 64'(bus.ocount), 64'd0);
    chk("reset_illegal", 64'(bus.illegal), 64'd0);
    #5 rst = 1'b1;
    step();

    // Single LD ABS push, then popped the following cycle
    bus.next_rdy = 1'b1;
    set_vec(0, 0, 32'h0000000C);
    bus.prev_vld = 1'b1;
    step();
    bus.prev_vld = 1'b0;
    repeat (3) step();

    // Stall: three offered, two held, head ages while stalled
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    set_vec(1, 5, 32'h11); step();
    set_vec(2, 7, 32'h22); step();
    set_vec(3, 9, 32'h33);
    chk("full_rdy_low", 64'(bus.rdy), 64'd0);
    repeat (3) step();
    bus.prev_vld = 1'b0;
    bus.next_rdy = 1'b1;
    repeat (4) step();

    // Stream 100 through a full buffer with continuous push and pop
    start = acc_cnt;
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    set_vec(0, 0, 32'h0);
    for (int c = 0; c < 400 && (acc_cnt - start) < 100; c++) begin
      step();
      if (acc_cnt - start >= 2) bus.next_rdy = 1'b1;
      set_vec(acc_cnt - start, (acc_cnt - start) % 50, 32'(acc_cnt - start) * 7);
    end
    bus.prev_vld = 1'b0;
    chk("stream_accepted", 64'(acc_cnt - start), 64'd100);
    repeat (4) step();

    // Flush with two held and an instruction on offer
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    set_vec(4, 1, 32'h44); step();
    set_vec(5, 2, 32'h55); step();
    set_vec(6, 3, 32'h66);
    bus.next_rdy = 1'b1;
    bus.branch_mispredict = 1'b1;
    step();
    bus.branch_mispredict = 1'b0;
    bus.prev_vld = 1'b0;
    chk("flush_occ", 64'(bus.occupancy), 64'd0);
    repeat (2) step();

    // Decode table streamed one at a time
    bus.next_rdy = 1'b1;
    bus.prev_vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_vec(k, k, 32'hA000_0000 + 32'(k));
      step();
    end
    bus.prev_vld = 1'b0;
    repeat (2) step();

    // Age saturation, then asynchronous reset mid-stall
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    set_vec(6, 62, 32'h77);
    step();
    bus.prev_vld = 1'b0;
    repeat (3) step();
    #1 rst = 1'b0;
    #1;
    chk("midrst_vld", 64'(bus.vld), 64'd0);
    chk("midrst_occ", 64'(bus.occupancy), 64'd0);
    chk("midrst_ocount", 64'(bus.ocount), 64'd0);
    #4 rst = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(bus.rdy), 64'd1);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/bpf_decode_buf.md
Name: bpf_decode_buf

Overview:
- Parametrised decode stage for the BPF CPU controller pipeline.
- Accepts raw instruction words from fetch through a valid/ready handshake and decodes the opcode subfields and datapath control bits.
- Holds decoded bundles in a BUF_DEPTH-entry FIFO, so fetch can keep streaming while execute stalls.
- Adds a mispredict flush, saturating per-entry age counters and an illegal-opcode flag.

Parameters:
- CODE_W, 8: opcode width, taken from the top of the instruction word.
- JMP_W, 8: width of each of the jt and jf fields.
- IMM_W, 32: immediate width.
- INST_W, CODE_W+2*JMP_W+IMM_W: instruction width; bits above this are ignored.
- BUF_DEPTH, 2: FIFO entries. Must be a power of 2 and at least 2.
- COUNT_W, 6: width of the age counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- inst  in  INST_W  instruction; fields from MSB down: opcode, jt, jf, imm.
- prev_vld  in  1  inst is valid.
- rdy  out  1  this stage can accept inst.
- icount  in  COUNT_W  age of inst on entry.
- branch_mispredict  in  1  flush request.
- next_rdy  in  1  downstream accepts the head entry.
- vld  out  1  head entry is valid.
- opcode  out  CODE_W  head opcode.
- jt  out  JMP_W  head jt field.
- jf  out  JMP_W  head jf field.
- imm  out  IMM_W  head immediate.
- B_sel  out  1  opcode[3].
- ALU_sel  out  4  opcode[7:4].
- addr_sel  out  1  1 = indirect address (addr_type==IND), 0 = absolute.
- rd_en  out  1  packet memory read enable.
- regfile_sel  out  1  1 = X, 0 = A.
- regfile_wr_en  out  1  scratch register file write enable.
- illegal  out  1  head opcode is undefined.
- ocount  out  COUNT_W  head entry age.
- occupancy  out  clog2(BUF_DEPTH)+1  number of entries held.

Behaviour:
- Opcode subfields:
  - class = opcode[2:0]: LD=0, LDX=1, ST=2, STX=3, ALU=4, JMP=5, RET=6, MISC=7.
  - addr_type = opcode[7:5]: IMM=0, ABS=1, IND=2, MEM=3, LEN=4, MSH=5.
- Decode is combinational on inst and is written into the FIFO at push:
  - rd_en = (class==LD and addr_type in {ABS,IND}) or (class==LDX and addr_type in {ABS,IND,MSH}).
  - regfile_sel = (class==STX).
  - regfile_wr_en = class in {ST,STX}.
  - illegal = (class==LD and addr_type in {MSH,6,7}) or (class==LDX and addr_type in {6,7}) or (class==RET and opcode[4:3]==3).
- Handshake:
  - push = prev_vld & rdy.
  - pop = vld & next_rdy.
  - rdy = (occupancy<BUF_DEPTH) or pop. A full buffer that pops accepts in the same cycle.
  - vld = (occupancy!=0).
  - All head outputs are driven from FIFO storage. They hold stable while vld=1 and next_rdy=0.
- Latency: an instruction pushed in cycle N is visible at the head in cycle N+1 if the buffer was empty.
- Simultaneous push and pop: occupancy is unchanged, pointers both advance, and no bubble is inserted.
- Pointer wrap: read and write pointers are clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. Full and empty are distinguished by occupancy.
- Age counter:
  - Stored age at push = icount+1, saturating at 2^COUNT_W-1.
  - Every held entry increments each cycle it is not popped, saturating at 2^COUNT_W-1.
  - ocount = head stored age.
- Flush:
  - branch_mispredict=1 clears occupancy and both pointers on the next edge.
  - rdy is forced to 0 during the flush cycle, so no push occurs.
  - vld still reflects the current state, but any pop in that cycle is discarded.
- Reset (rst=0, asynchronous):
  - occupancy=0, pointers=0, vld=0.
  - All head outputs are 0, including illegal=0 and ocount=0.
  - rdy=1 once rst deasserts.
  - Reset mid-transfer drops all entries.
- Empty buffer: all decoded head outputs read 0.

Test Plan:
- Single push of opcode 0x20 (LD ABS), imm=0x0000000C, icount=0 → next cycle vld=1, rd_en=1, addr_sel=0, ocount=1, illegal=0; pop with next_rdy=1 → vld=0.
- next_rdy=0, push 3 insts with BUF_DEPTH=2 → rdy=0 after 2 pushes, occupancy=2. Head holds the first inst, and its ocount increments by 1 per stall cycle.
- Full buffer with next_rdy=1 and prev_vld=1 streaming 100 insts → one push and one pop per cycle, in-order output, no loss or duplication across pointer wraps.
- Two entries held, assert branch_mispredict with prev_vld=1 → rdy=0 that cycle, occupancy=0 and vld=0 next cycle, the offered inst is not stored.
- Opcode 0x03 (STX) → regfile_sel=1, regfile_wr_en=1; 0xA0 (LD MSH) → illegal=1; 0xB1 (LDX MSH) → rd_en=1, illegal=0.
- icount=62 with 3 stall cycles → ocount 63, 63, 63 (saturated); rst pulse low mid-stall → vld=0 immediately, rdy=1 after release.
